instr_fetch_ctrl: RTL and testbench

//  Sequences the byte-addressed instruction memory: holds the PC and drives the memory address.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 49 ++++
 rtl/instr_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: FSM state encoding and the
// {pc, instr} record carried through the fetch buffer.
package fetch_pkg;

    localparam int INSTR_BYTES   = 4;
    localparam int FETCH_ADDR_W  = 7;
    localparam int FETCH_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// BUF_DEPTH-deep FIFO of fetched {pc, instr} entries. Flush wins over push;
// head reads as zero while the buffer is empty.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    fetch_entry_t   mem [BUF_DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, branch redirect, end-of-memory halt.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects in a sticky FAULT state.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int MEM_SIZE  = 128,
    parameter int ADDR_W    = $clog2(MEM_SIZE),
    parameter int INSTR_W   = 32,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               end_of_mem,
    output logic               fault,
    output logic [1:0]         state_dbg
);

    // The PC keeps one bit above the address width so the step past the last
    // word lands on MEM_SIZE (seen as > MEM_SIZE-4) instead of wrapping to 0.
    localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'(MEM_SIZE - INSTR_BYTES);
    localparam logic [ADDR_W:0] STEP    = (ADDR_W+1)'(INSTR_BYTES);

    fetch_state_e    state;
    logic [ADDR_W:0] pc;
    logic [ADDR_W:0] redir_tgt;
    logic            redir_act;
    logic            align_bad;
    logic            halt_cond;
    logic            pop;
    logic            push;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign align_bad = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_align;
    assign unused_align = ^redirect_pc[1:0];
    assign align_bad    = 1'b0;
`endif

    assign redir_tgt = {1'b0, redirect_pc[ADDR_W-1:2], 2'b00};
    assign redir_act = redirect_valid && (state != FAULT);
    assign halt_cond = (pc > LAST_PC);
    assign pop       = instr_valid && instr_ready;
    assign push      = (state == RUN) && !redir_act && !halt_cond && (!buf_full || pop);

    assign push_entry.pc    = pc[ADDR_W-1:0];
    assign push_entry.instr = imem_data;

    fetch_buf #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redir_act),
        .din  (push_entry),
        .full (buf_full),
        .empty(buf_empty),
        .head (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= (ADDR_W+1)'(RESET_PC);
        end else if (redir_act) begin
            if (align_bad) begin
                state <= FAULT;
            end else begin
                pc <= redir_tgt;
                // A redirect in IDLE only retargets the PC unless start arrives with it.
                if (state != IDLE || start) state <= RUN;
            end
        end else begin
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: begin
                    if (halt_cond) state <= HALT;
                    else if (push) pc <= pc + STEP;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc[ADDR_W-1:0];
    assign instr_valid = !buf_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign end_of_mem  = (state == HALT);
    assign fault       = (state == FAULT);
    assign state_dbg   = state;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: cycle table for the start sequence,
// directed sequences for stall, redirect, end-of-memory, reset and alignment.
module tb_instr_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [6:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  instr_pc;
    logic        end_of_mem;
    logic        fault;
    logic [1:0]  state_dbg;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [38:0] exp_q[$];
    logic [6:0]  last_hs_pc = '0;

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [6:0]  exp_pc;
        logic [31:0] exp_instr;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[5];

    instr_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .end_of_mem    (end_of_mem),
        .fault         (fault),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        case (a)
            7'h00:   return 32'hffc4a303;
            7'h04:   return 32'h00832383;
            7'h08:   return 32'h0064a423;
            default: return 32'h0;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    function automatic logic [38:0] exp_entry(input logic [6:0] a);
        return {a, mem_word(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Handshake monitor: the pop happens at the coming posedge, inputs are stable here.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got pc %0h instr %0h expected none", instr_pc, instr);
            end else begin
                check("pop", {25'd0, instr_pc, instr}, {25'd0, exp_q.pop_front()});
            end
            last_hs_pc = instr_pc;
        end
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 7'h00, 32'h0,        RUN};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 7'h00, 32'hffc4a303, RUN};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 7'h04, 32'h00832383, RUN};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 7'h08, 32'h0064a423, RUN};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 7'h0c, 32'h0,        RUN};

        // Reset state
        do_reset();
        check("rst_valid", instr_valid, 0);
        check("rst_eom", end_of_mem, 0);
        check("rst_fault", fault, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_state", state_dbg, IDLE);

        // 1) start with ready high, cycle table
        for (int a = 0; a <= 8; a += 4) exp_q.push_back(exp_entry(7'(a)));
        for (int i = 0; i < 5; i++) begin
            start = vecs[i].start;
            instr_ready = vecs[i].ready;
            tick();
            check($sformatf("t1_valid[%0d]", i), instr_valid, vecs[i].exp_valid);
            check($sformatf("t1_state[%0d]", i), state_dbg, vecs[i].exp_state);
            if (vecs[i].exp_valid) begin
                check($sformatf("t1_pc[%0d]", i), instr_pc, vecs[i].exp_pc);
                check($sformatf("t1_instr[%0d]", i), instr, vecs[i].exp_instr);
            end
        end
        check("t1_drained", exp_q.size(), 0);

        // 2) back-pressure for 5 cycles
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", instr_valid, 1);
            check("t2_hold_pc", instr_pc, 0);
            check("t2_hold_instr", instr, 32'hffc4a303);
            tick();
        end
        check("t2_pc_stalled", imem_addr, 8);
        for (int a = 0; a <= 8; a += 4) exp_q.push_back(exp_entry(7'(a)));
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        check("t2_drained", exp_q.size(), 0);

        // 3) redirect to 0x08 while buffer holds 0,4 and decode takes the head
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        exp_q.push_back(exp_entry(7'h00));
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 7'h08;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        check("t3_flush_valid", instr_valid, 0);
        check("t3_redir_addr", imem_addr, 8);
        tick();
        check("t3_next_valid", instr_valid, 1);
        check("t3_next_pc", instr_pc, 8);
        check("t3_next_instr", instr, 32'h0064a423);
        check("t3_drained", exp_q.size(), 0);

        // 4) run to end of memory, then redirect back to 0
        do_reset();
        for (int a = 0; a <= 124; a += 4) exp_q.push_back(exp_entry(7'(a)));
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!end_of_mem && cyc < 80) begin
                tick();
                cyc++;
            end
            if (!end_of_mem) begin
                n_cmp++;
                n_err++;
                $display("FAIL t4_eom_timeout: got end_of_mem 0 after %0d cycles expected 1", cyc);
            end
        end
        check("t4_eom_valid", instr_valid, 0);
        check("t4_eom_state", state_dbg, HALT);
        check("t4_last_pc", last_hs_pc, 7'h7c);
        check("t4_drained", exp_q.size(), 0);
        redirect_valid = 1'b1;
        redirect_pc = 7'h00;
        tick();
        redirect_valid = 1'b0;
        check("t4_eom_clear", end_of_mem, 0);
        check("t4_restart_state", state_dbg, RUN);
        exp_q.push_back(exp_entry(7'h00));
        tick();
        check("t4_restart_valid", instr_valid, 1);
        check("t4_restart_pc", instr_pc, 0);
        tick();
        instr_ready = 1'b0;
        check("t4_restart_drained", exp_q.size(), 0);

        // 5) reset while valid && !ready
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t5_pre_valid", instr_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", instr_valid, 0);
        check("t5_state", state_dbg, IDLE);
        check("t5_addr", imem_addr, 0);
        check("t5_instr", instr, 0);
        check("t5_instr_pc", instr_pc, 0);

        // 6) misaligned redirect to 0x06
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 7'h06;
        tick();
        redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        check("t6_fault", fault, 1);
        check("t6_state", state_dbg, FAULT);
        check("t6_valid", instr_valid, 0);
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 7'h00;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t6_fault_sticky", fault, 1);
        check("t6_state_sticky", state_dbg, FAULT);
        check("t6_valid_sticky", instr_valid, 0);
`else
        check("t6_fault", fault, 0);
        check("t6_state", state_dbg, RUN);
        check("t6_valid", instr_valid, 0);
        check("t6_addr", imem_addr, 4);
        tick();
        check("t6_next_valid", instr_valid, 1);
        check("t6_next_pc", instr_pc, 4);
        check("t6_next_instr", instr, 32'h00832383);
`endif
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
